flappy_game_ctrl: RTL

Game-sequencing controller for the Flappy Bird VGA design. It owns the bird's vertical physics, one scrolling pipe with a pseudo-random gap, collision detection, scoring and the IDLE/PLAY/DEAD game state machine. It sits between the keyboard block (`spacebar_pressed` → `flap`) and the pixel-drawing logic, which consumes `bird_y`, `pipe_x`, `gap_y` against the VGA `x`/`y` counters. All motion advances once per `frame_tick`.

---
 rtl/flappy_game_ctrl_if.sv | 22 ++
 rtl/flappy_game_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the Flappy Bird game controller and its neighbours:
// tick/flap inputs from the timing and keyboard blocks, positions and status to the pixel logic.
interface flappy_game_ctrl_if;
  logic       frame_tick;
  logic       flap;
  logic [9:0] bird_y;
  logic [9:0] pipe_x;
  logic [9:0] gap_y;
  logic [7:0] score;
  logic [1:0] state;
  logic       game_over;

  modport master (
    output frame_tick, flap,
    input  bird_y, pipe_x, gap_y, score, state, game_over
  );

  modport slave (
    input  frame_tick, flap,
    output bird_y, pipe_x, gap_y, score, state, game_over
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: bird physics, one scrolling pipe with LFSR gap, collision,
// scoring and the IDLE/PLAY/DEAD state machine, all advancing once per frame_tick.
module flappy_game_ctrl #(
  parameter int BIRD_X      = 200,
  parameter int BIRD_SIZE   = 16,
  parameter int BIRD_Y0     = 232,
  parameter int GRAVITY     = 1,
  parameter int FLAP_VEL    = -8,
  parameter int VMAX        = 8,
  parameter int PIPE_W      = 40,
  parameter int GAP_H       = 120,
  parameter int PIPE_SPEED  = 2,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int DEAD_FRAMES = 60
) (
  input logic               clk,
  input logic               rst_n,
  flappy_game_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StPlay = 2'b01;
  localparam logic [1:0] StDead = 2'b10;

  localparam int CntW = $clog2(DEAD_FRAMES + 1);

  localparam logic [9:0]         BirdY0    = 10'(BIRD_Y0);
  localparam logic [9:0]         ScreenW   = 10'(SCREEN_W);
  localparam logic [9:0]         PipeSpeed = 10'(PIPE_SPEED);
  localparam logic [9:0]         GapY0     = 10'd180;
  localparam logic [9:0]         GapMin    = 10'd40;
  localparam logic [10:0]        FloorY    = 11'(SCREEN_H - BIRD_SIZE);
  localparam logic [10:0]        BirdL     = 11'(BIRD_X);
  localparam logic [10:0]        BirdR     = 11'(BIRD_X + BIRD_SIZE);
  localparam logic [10:0]        BirdSz    = 11'(BIRD_SIZE);
  localparam logic [10:0]        PipeW     = 11'(PIPE_W);
  localparam logic [10:0]        GapH      = 11'(GAP_H);
  localparam logic signed [6:0]  Grav      = 7'(GRAVITY);
  localparam logic signed [6:0]  VmaxS     = 7'(VMAX);
  localparam logic signed [5:0]  FlapV     = 6'(FLAP_VEL);
  localparam logic [CntW-1:0]    DeadN     = CntW'(DEAD_FRAMES);

  logic [1:0]        state_q, state_d;
  logic [9:0]        bird_y_q, bird_y_d, pipe_x_q, pipe_x_d, gap_y_q, gap_y_d;
  logic signed [5:0] vel_q, vel_d;
  logic [7:0]        score_q, score_d, lfsr_q, lfsr_d;
  logic              passed_q, passed_d, game_over_q, game_over_d;
  logic [CntW-1:0]   dead_cnt_q, dead_cnt_d;
  logic              flap_s1_q, flap_s2_q, flap_s3_q;
  logic              flap_pending_q, flap_pending_d;

  logic              flap_edge, flap_now, respawn, overlap, out_gap, collide;
  logic signed [6:0] vel_sum;
  logic signed [5:0] vel_play;
  logic signed [10:0] y_sum;
  logic [9:0]        bird_next, pipe_next, new_gap;
  logic [10:0]       pipe_end;

  always_comb begin
    flap_edge = flap_s2_q & ~flap_s3_q;
    flap_now  = flap_pending_q | flap_edge;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    new_gap   = GapMin + {2'b00, lfsr_q};

    vel_sum  = {vel_q[5], vel_q} + Grav;
    vel_play = flap_now ? FlapV : ((vel_sum > VmaxS) ? VmaxS[5:0] : vel_sum[5:0]);
    y_sum    = {1'b0, bird_y_q} + {{5{vel_play[5]}}, vel_play};
    // Hitting the ceiling just clamps; the floor clamp is caught by the collision check.
    if (y_sum[10])             bird_next = '0;
    else if (y_sum >= FloorY)  bird_next = FloorY[9:0];
    else                       bird_next = y_sum[9:0];

    respawn   = pipe_x_q < PipeSpeed;
    pipe_next = respawn ? ScreenW : pipe_x_q - PipeSpeed;
    pipe_end  = {1'b0, pipe_next} + PipeW;

    overlap = (BirdR > {1'b0, pipe_x_q}) && (BirdL < {1'b0, pipe_x_q} + PipeW);
    out_gap = (bird_y_q < gap_y_q) || ({1'b0, bird_y_q} + BirdSz > {1'b0, gap_y_q} + GapH);
    collide = (overlap && out_gap) || ({1'b0, bird_y_q} >= FloorY);

    state_d        = state_q;
    bird_y_d       = bird_y_q;
    vel_d          = vel_q;
    pipe_x_d       = pipe_x_q;
    gap_y_d        = gap_y_q;
    score_d        = score_q;
    passed_d       = passed_q;
    dead_cnt_d     = dead_cnt_q;
    game_over_d    = 1'b0;
    flap_pending_d = bus.frame_tick ? 1'b0 : flap_now;

    unique case (state_q)
      StIdle: begin
        if (bus.frame_tick && flap_now) begin
          state_d  = StPlay;
          score_d  = '0;
          vel_d    = '0;
          bird_y_d = BirdY0;
          pipe_x_d = ScreenW;
          gap_y_d  = new_gap;
          passed_d = 1'b0;
        end
      end
      StPlay: begin
        if (collide) begin
          state_d     = StDead;
          game_over_d = 1'b1;
          dead_cnt_d  = '0;
        end else if (bus.frame_tick) begin
          vel_d    = vel_play;
          bird_y_d = bird_next;
          pipe_x_d = pipe_next;
          if (respawn) begin
            gap_y_d  = new_gap;
            passed_d = 1'b0;
          end else if (!passed_q && (pipe_end < BirdL)) begin
            passed_d = 1'b1;
            score_d  = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end
        end
      end
      StDead: begin
        if (dead_cnt_q != DeadN) begin
          flap_pending_d = 1'b0;
          if (bus.frame_tick) dead_cnt_d = dead_cnt_q + 1'b1;
        end else if (bus.frame_tick && flap_now) begin
          state_d  = StIdle;
          bird_y_d = BirdY0;
          vel_d    = '0;
          pipe_x_d = ScreenW;
          gap_y_d  = GapY0;
          passed_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      bird_y_q       <= BirdY0;
      vel_q          <= '0;
      pipe_x_q       <= ScreenW;
      gap_y_q        <= GapY0;
      score_q        <= '0;
      passed_q       <= 1'b0;
      game_over_q    <= 1'b0;
      lfsr_q         <= 8'hA5;
      dead_cnt_q     <= '0;
      flap_s1_q      <= 1'b0;
      flap_s2_q      <= 1'b0;
      flap_s3_q      <= 1'b0;
      flap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bird_y_q       <= bird_y_d;
      vel_q          <= vel_d;
      pipe_x_q       <= pipe_x_d;
      gap_y_q        <= gap_y_d;
      score_q        <= score_d;
      passed_q       <= passed_d;
      game_over_q    <= game_over_d;
      lfsr_q         <= lfsr_d;
      dead_cnt_q     <= dead_cnt_d;
      flap_s1_q      <= bus.flap;
      flap_s2_q      <= flap_s1_q;
      flap_s3_q      <= flap_s2_q;
      flap_pending_q <= flap_pending_d;
    end
  end

  assign bus.bird_y    = bird_y_q;
  assign bus.pipe_x    = pipe_x_q;
  assign bus.gap_y     = gap_y_q;
  assign bus.score     = score_q;
  assign bus.state     = state_q;
  assign bus.game_over = game_over_q;

endmodule
